// File: rtl/rns_to_bin.sv
// rns_to_bin: sequential mixed-radix reverse converter, moduli {233,239,241,251}.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/x_rns accept one packed
// residue word; out_valid/out_ready/y/err present the 32-bit result.
// Optional macro RNS_SIGNED_OUT_EN: y is presented as signed two's complement.
module rns_to_bin (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x_rns,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        err
);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_D2   = 4'd1;
    localparam logic [3:0] S_D3A  = 4'd2;
    localparam logic [3:0] S_D3B  = 4'd3;
    localparam logic [3:0] S_D4A  = 4'd4;
    localparam logic [3:0] S_D4B  = 4'd5;
    localparam logic [3:0] S_D4C  = 4'd6;
    localparam logic [3:0] S_H1   = 4'd7;
    localparam logic [3:0] S_H2   = 4'd8;
    localparam logic [3:0] S_H3   = 4'd9;
    localparam logic [3:0] S_OUT  = 4'd10;

    // Reduction select for the shared modular multiplier
    localparam logic [1:0] SEL_239 = 2'd0;
    localparam logic [1:0] SEL_241 = 2'd1;
    localparam logic [1:0] SEL_251 = 2'd2;

`ifdef RNS_SIGNED_OUT_EN
    localparam logic [31:0] M_RANGE = 32'd3368562317;
    localparam logic [31:0] HALF_M  = 32'd1684281159;
`endif

    logic [3:0]  state;
    logic [23:0] x_q;      // r2..r4; r1 lives in a1
    logic [7:0]  a1;
    logic [7:0]  a2;
    logic [7:0]  a3;
    logic [7:0]  a4;
    logic [7:0]  t_q;
    logic [7:0]  u_q;
    logic [31:0] h_q;
    logic        err_q;

    logic [7:0]  r2;
    logic [7:0]  r3;
    logic [7:0]  r4;

    assign r2 = x_q[7:0];
    assign r3 = x_q[15:8];
    assign r4 = x_q[23:16];

    assign in_ready = (state == S_IDLE);

    // ---------------------------------------------------------------
    // Shared modular unit: ((op_a - op_b) mod m) * op_k mod m
    // ---------------------------------------------------------------
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [7:0]  op_m;
    logic [7:0]  op_k;
    logic [1:0]  op_sel;
    logic [8:0]  diff9;
    logic [7:0]  diff;
    logic [15:0] prod;
    logic [15:0] rem239;
    logic [15:0] rem241;
    logic [15:0] rem251;
    logic [7:0]  mod_res;

    always_comb begin
        op_a   = 8'd0;
        op_b   = 8'd0;
        op_m   = 8'd239;
        op_k   = 8'd0;
        op_sel = SEL_239;
        unique case (state)
            S_D2: begin
                op_a   = r2;
                op_b   = a1;
                op_m   = 8'd239;
                op_k   = 8'd199;
                op_sel = SEL_239;
            end
            S_D3A: begin
                op_a   = r3;
                op_b   = a1;
                op_m   = 8'd241;
                op_k   = 8'd30;
                op_sel = SEL_241;
            end
            S_D3B: begin
                op_a   = t_q;
                op_b   = a2;
                op_m   = 8'd241;
                op_k   = 8'd120;
                op_sel = SEL_241;
            end
            S_D4A: begin
                op_a   = r4;
                op_b   = a1;
                op_m   = 8'd251;
                op_k   = 8'd237;
                op_sel = SEL_251;
            end
            S_D4B: begin
                op_a   = u_q;
                op_b   = a2;
                op_m   = 8'd251;
                op_k   = 8'd230;
                op_sel = SEL_251;
            end
            S_D4C: begin
                op_a   = u_q;
                op_b   = a3;
                op_m   = 8'd251;
                op_k   = 8'd25;
                op_sel = SEL_251;
            end
            default: begin
                op_a   = 8'd0;
                op_b   = 8'd0;
                op_m   = 8'd239;
                op_k   = 8'd0;
                op_sel = SEL_239;
            end
        endcase
    end

    always_comb begin
        // Negative difference wraps by adding m; the result is then < m.
        // Out-of-range raw bytes may exceed m here, but the reduction
        // below still bounds the digit and the result is discarded.
        if (op_a >= op_b) begin
            diff9 = {1'b0, op_a} - {1'b0, op_b};
        end else begin
            diff9 = {1'b0, op_a} + {1'b0, op_m} - {1'b0, op_b};
        end
        diff   = diff9[7:0];
        prod   = {8'd0, diff} * {8'd0, op_k};
        rem239 = prod % 16'd239;
        rem241 = prod % 16'd241;
        rem251 = prod % 16'd251;
        unique case (op_sel)
            SEL_241: mod_res = rem241[7:0];
            SEL_251: mod_res = rem251[7:0];
            default: mod_res = rem239[7:0];
        endcase
    end

    // ---------------------------------------------------------------
    // Horner accumulation: h = add + k * base, always 32-bit unsigned
    // ---------------------------------------------------------------
    logic [31:0] hb_base;
    logic [31:0] hb_k;
    logic [31:0] hb_add;
    logic [31:0] h_next;
    logic [31:0] y_final;

    always_comb begin
        hb_base = h_q;
        hb_k    = 32'd0;
        hb_add  = 32'd0;
        unique case (state)
            S_H1: begin
                hb_base = {24'd0, a4};
                hb_k    = 32'd241;
                hb_add  = {24'd0, a3};
            end
            S_H2: begin
                hb_base = h_q;
                hb_k    = 32'd239;
                hb_add  = {24'd0, a2};
            end
            S_H3: begin
                hb_base = h_q;
                hb_k    = 32'd233;
                hb_add  = {24'd0, a1};
            end
            default: begin
                hb_base = h_q;
                hb_k    = 32'd0;
                hb_add  = 32'd0;
            end
        endcase
        h_next = hb_add + hb_base * hb_k;
`ifdef RNS_SIGNED_OUT_EN
        // Upper half of the range maps to negatives; wraps mod 2^32
        if (h_next >= HALF_M) begin
            y_final = h_next - M_RANGE;
        end else begin
            y_final = h_next;
        end
`else
        y_final = h_next;
`endif
    end

    // ---------------------------------------------------------------
    // Control FSM and state registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            x_q       <= 24'd0;
            a1        <= 8'd0;
            a2        <= 8'd0;
            a3        <= 8'd0;
            a4        <= 8'd0;
            t_q       <= 8'd0;
            u_q       <= 8'd0;
            h_q       <= 32'd0;
            err_q     <= 1'b0;
            out_valid <= 1'b0;
            y         <= 32'd0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q   <= x_rns[31:8];
                        a1    <= x_rns[7:0];
                        err_q <= (x_rns[7:0]   >= 8'd233) |
                                 (x_rns[15:8]  >= 8'd239) |
                                 (x_rns[23:16] >= 8'd241) |
                                 (x_rns[31:24] >= 8'd251);
                        state <= S_D2;
                    end
                end
                S_D2: begin
                    a2    <= mod_res;
                    state <= S_D3A;
                end
                S_D3A: begin
                    t_q   <= mod_res;
                    state <= S_D3B;
                end
                S_D3B: begin
                    a3    <= mod_res;
                    state <= S_D4A;
                end
                S_D4A: begin
                    u_q   <= mod_res;
                    state <= S_D4B;
                end
                S_D4B: begin
                    u_q   <= mod_res;
                    state <= S_D4C;
                end
                S_D4C: begin
                    a4    <= mod_res;
                    state <= S_H1;
                end
                S_H1: begin
                    h_q   <= h_next;
                    state <= S_H2;
                end
                S_H2: begin
                    h_q   <= h_next;
                    state <= S_H3;
                end
                S_H3: begin
                    h_q       <= h_next;
                    y         <= err_q ? 32'd0 : y_final;
                    err       <= err_q;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rns_to_bin.sv
// tb_rns_to_bin: directed checks of the RNS reverse converter.
// Covers reset, latency, values, range error, backpressure and abort.
module tb_rns_to_bin;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_rns;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        err;

    int checks = 0;
    int errors = 0;

    rns_to_bin dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_rns     (x_rns),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .err       (err)
    );

    always #5 clk = ~clk;

`ifdef RNS_SIGNED_OUT_EN
    localparam logic [31:0] EXP_MAX = 32'hFFFFFFFF;
`else
    localparam logic [31:0] EXP_MAX = 32'd3368562316;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Accept one word, wait for out_valid (bounded), check latency and result
    task automatic run(input logic [31:0] x, input logic [31:0] ey,
                       input logic ee, input string tag);
        int lat;
        chk({tag, "_ready_pre"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        x_rns    = x;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (out_valid) break;
        end
        chk({tag, "_latency"}, lat, 32'd9);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, ee});
    endtask

    // With out_ready high the handshake completes on the next edge
    task automatic finish_hs(input string tag);
        tick();
        chk({tag, "_ovalid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        x_rns     = 32'd0;
        out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);

        run(32'h00000000, 32'd0, 1'b0, "zero");
        finish_hs("zero");
        run(32'h01010101, 32'd1, 1'b0, "one");
        finish_hs("one");
        run(32'hF7242C44, 32'd1000, 1'b0, "k1000");
        finish_hs("k1000");
        run(32'hFAF0EEE8, EXP_MAX, 1'b0, "max");
        finish_hs("max");
        run(32'h000000E9, 32'd0, 1'b1, "range");
        finish_hs("range");

        // Backpressure: hold the result for 5 cycles
        out_ready = 1'b0;
        run(32'hF7242C44, 32'd1000, 1'b0, "bp");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                x_rns    = 32'h01010101;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_y", y, 32'd1000);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_hs("bp");
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("bp_no_capture", seen, 32'd0);

        // Reset while in D3B aborts the conversion
        in_valid = 1'b1;
        x_rns    = 32'hF7242C44;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_stale", seen, 32'd0);
        run(32'h01010101, 32'd1, 1'b0, "post_abort");
        finish_hs("post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
